// File: rtl/mbinit_param_negotiator.sv
// Receive-side responder for the MBINIT PARAM step: waits for a configuration
// request, negotiates its parameter field against local capability and replies.
module mbinit_param_negotiator #(
    parameter int                      SB_MSG_WIDTH   = 4,
    parameter int                      PARAM_WIDTH    = 16,
    parameter logic [SB_MSG_WIDTH-1:0] REQ_CODE       = 4'b0001,
    parameter logic [SB_MSG_WIDTH-1:0] RESP_CODE      = 4'b0010,
    parameter int                      TIMEOUT_CYCLES = 1024
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic                    i_sb_busy,
    input  logic                    i_sb_busy_fall,
    input  logic                    i_sb_valid,
    input  logic [SB_MSG_WIDTH-1:0] i_decoded_sb_msg,
    input  logic [PARAM_WIDTH-1:0]  i_sb_data,
    input  logic [PARAM_WIDTH-1:0]  i_local_cap,
    input  logic [PARAM_WIDTH-1:0]  i_mandatory_mask,
    output logic [SB_MSG_WIDTH-1:0] o_encoded_sb_msg,
    output logic [PARAM_WIDTH-1:0]  o_sb_data,
    output logic                    o_msg_valid,
    output logic [PARAM_WIDTH-1:0]  o_negotiated,
    output logic                    o_check_en,
    output logic                    o_done,
    output logic                    o_error
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_REQ  = 3'd1;
    localparam logic [2:0] ST_CHECK     = 3'd2;
    localparam logic [2:0] ST_WAIT_SB   = 3'd3;
    localparam logic [2:0] ST_SEND_RESP = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;
    localparam logic [2:0] ST_ERROR     = 3'd6;

    // A disabled timeout still needs a 1-bit counter to keep widths legal.
    localparam int              CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit               TO_ON    = (TIMEOUT_CYCLES != 0);

    logic [2:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PARAM_WIDTH-1:0]  remote_q, remote_d;
    logic [PARAM_WIDTH-1:0]  neg_q, neg_d;
    logic [SB_MSG_WIDTH-1:0] code_q, code_d;
    logic [PARAM_WIDTH-1:0]  tx_data_q, tx_data_d;
    logic                    msg_valid_q, msg_valid_d;
    logic                    check_en_q, check_en_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic                    req_hit;
    logic                    timeout_hit;

    assign req_hit     = i_sb_valid && (i_decoded_sb_msg == REQ_CODE);
    assign timeout_hit = TO_ON && (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        remote_d = remote_q;
        neg_d    = neg_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (i_en) state_d = ST_WAIT_REQ;
            end
            ST_WAIT_REQ: begin
                // A request in the last allowed cycle takes priority over timeout.
                if (req_hit) begin
                    state_d  = ST_CHECK;
                    remote_d = i_sb_data;
                    neg_d    = i_sb_data & i_local_cap;
                end else if (timeout_hit) begin
                    state_d = ST_ERROR;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CHECK: begin
                if ((remote_q & i_local_cap & i_mandatory_mask) != i_mandatory_mask)
                    state_d = ST_ERROR;
                else
                    state_d = ST_WAIT_SB;
            end
            ST_WAIT_SB: begin
                if (!i_sb_busy) state_d = ST_SEND_RESP;
            end
            ST_SEND_RESP: begin
                if (i_sb_busy_fall) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_DONE;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_IDLE;
        endcase

        if (!i_en) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            remote_d = remote_q;
            neg_d    = neg_q;
        end
    end

    // Outputs are decoded from the next state so they align with state entry.
    always_comb begin
        check_en_d  = (state_d == ST_CHECK);
        msg_valid_d = (state_d == ST_SEND_RESP);
        code_d      = (state_d == ST_SEND_RESP) ? RESP_CODE : '0;
        tx_data_d   = (state_d == ST_SEND_RESP) ? neg_d : '0;
        done_d      = (state_d == ST_DONE);
        error_d     = (state_d == ST_ERROR);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            remote_q    <= '0;
            neg_q       <= '0;
            code_q      <= '0;
            tx_data_q   <= '0;
            msg_valid_q <= 1'b0;
            check_en_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            remote_q    <= remote_d;
            neg_q       <= neg_d;
            code_q      <= code_d;
            tx_data_q   <= tx_data_d;
            msg_valid_q <= msg_valid_d;
            check_en_q  <= check_en_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign o_encoded_sb_msg = code_q;
    assign o_sb_data        = tx_data_q;
    assign o_msg_valid      = msg_valid_q;
    assign o_negotiated     = neg_q;
    assign o_check_en       = check_en_q;
    assign o_done           = done_q;
    assign o_error          = error_q;

endmodule

// File: tb/tb_mbinit_param_negotiator.sv
// Randomised self-checking bench: one responder with the long timeout and one
// with an 8-cycle timeout share the same stimulus.
module tb_mbinit_param_negotiator;

    localparam logic [3:0] REQ  = 4'b0001;
    localparam logic [3:0] RESP = 4'b0010;
    localparam int         TO_B = 8;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_en = 1'b0;
    logic        i_sb_busy = 1'b0;
    logic        i_sb_busy_fall = 1'b0;
    logic        i_sb_valid = 1'b0;
    logic [3:0]  i_decoded_sb_msg = '0;
    logic [15:0] i_sb_data = '0;
    logic [15:0] i_local_cap = '0;
    logic [15:0] i_mandatory_mask = '0;

    logic [3:0]  a_code, b_code;
    logic [15:0] a_data, b_data, a_neg, b_neg;
    logic        a_valid, b_valid, a_chk, b_chk, a_done, b_done, a_err, b_err;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_neg = '0;

    always #5 i_clk = ~i_clk;

    mbinit_param_negotiator #(.SB_MSG_WIDTH(4), .PARAM_WIDTH(16), .REQ_CODE(REQ),
        .RESP_CODE(RESP), .TIMEOUT_CYCLES(1024)) dut_a (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_sb_busy(i_sb_busy),
        .i_sb_busy_fall(i_sb_busy_fall), .i_sb_valid(i_sb_valid),
        .i_decoded_sb_msg(i_decoded_sb_msg), .i_sb_data(i_sb_data),
        .i_local_cap(i_local_cap), .i_mandatory_mask(i_mandatory_mask),
        .o_encoded_sb_msg(a_code), .o_sb_data(a_data), .o_msg_valid(a_valid),
        .o_negotiated(a_neg), .o_check_en(a_chk), .o_done(a_done), .o_error(a_err));

    mbinit_param_negotiator #(.SB_MSG_WIDTH(4), .PARAM_WIDTH(16), .REQ_CODE(REQ),
        .RESP_CODE(RESP), .TIMEOUT_CYCLES(TO_B)) dut_b (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_sb_busy(i_sb_busy),
        .i_sb_busy_fall(i_sb_busy_fall), .i_sb_valid(i_sb_valid),
        .i_decoded_sb_msg(i_decoded_sb_msg), .i_sb_data(i_sb_data),
        .i_local_cap(i_local_cap), .i_mandatory_mask(i_mandatory_mask),
        .o_encoded_sb_msg(b_code), .o_sb_data(b_data), .o_msg_valid(b_valid),
        .o_negotiated(b_neg), .o_check_en(b_chk), .o_done(b_done), .o_error(b_err));

    // Outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Drop enable: every flag must clear, the negotiated field must be retained.
    task automatic go_idle(input string tag);
        i_en = 1'b0; i_sb_valid = 1'b0; i_sb_busy = 1'b0; i_sb_busy_fall = 1'b0;
        step();
        checks++;
        if ({a_valid, a_chk, a_done, a_err, a_code, a_data} !== 24'h0 || a_neg !== exp_neg) begin
            failures++;
            $display("FAIL %s idle_a: flags=%b code=%h data=%h neg=%h, required 0/0/0 neg=%h",
                     tag, {a_valid, a_chk, a_done, a_err}, a_code, a_data, a_neg, exp_neg);
        end
        checks++;
        if ({b_valid, b_chk, b_done, b_err} !== 4'b0) begin
            failures++;
            $display("FAIL %s idle_b: flags=%b required 0000", tag, {b_valid, b_chk, b_done, b_err});
        end
        $display("txn %s: idle a_neg=%h", tag, a_neg);
    endtask

    // Full responder transaction: request in WAIT_REQ cycle d, w busy cycles
    // in WAIT_SB, h held cycles in SEND_RESP before the busy fall pulse.
    task automatic run_flow(input int d, input logic [15:0] data, input logic [15:0] cap,
                            input logic [15:0] mask, input int w, input int h,
                            input bit abort, input string tag);
        logic [15:0] neg;
        bit          err;
        neg = data & cap;
        err = ((neg & mask) != mask);
        i_local_cap = cap; i_mandatory_mask = mask;
        i_en = 1'b1;
        step();
        for (int k = 1; k < d; k++) begin
            i_sb_valid = ($urandom_range(0, 2) == 0);
            i_decoded_sb_msg = RESP;
            i_sb_data = 16'($urandom);
            step();
            checks++;
            if (a_chk !== 1'b0 || a_err !== 1'b0 || b_err !== (k >= TO_B)) begin
                failures++;
                $display("FAIL %s wait_k%0d: a_chk=%b a_err=%b b_err=%b, required 0 0 %b",
                         tag, k, a_chk, a_err, b_err, (k >= TO_B));
            end
        end
        i_sb_valid = 1'b1; i_decoded_sb_msg = REQ; i_sb_data = data;
        step();
        i_sb_valid = 1'b0; i_sb_data = 16'($urandom);
        exp_neg = neg;
        checks++;
        if (a_chk !== 1'b1 || a_neg !== neg || b_chk !== (d <= TO_B)) begin
            failures++;
            $display("FAIL %s check: a_chk=%b a_neg=%h b_chk=%b, required 1 %h %b",
                     tag, a_chk, a_neg, b_chk, neg, (d <= TO_B));
        end
        step();
        checks++;
        if (a_chk !== 1'b0 || a_err !== err || a_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s post_check: chk=%b err=%b valid=%b, required 0 %b 0",
                     tag, a_chk, a_err, a_valid, err);
        end
        if (err) begin
            step();
            checks++;
            if (a_err !== 1'b1 || a_valid !== 1'b0 || a_done !== 1'b0 || a_neg !== neg) begin
                failures++;
                $display("FAIL %s err_hold: err=%b valid=%b done=%b neg=%h, required 1 0 0 %h",
                         tag, a_err, a_valid, a_done, a_neg, neg);
            end
            $display("txn %s: d=%0d data=%h cap=%h mask=%h -> error", tag, d, data, cap, mask);
            return;
        end
        for (int k = 0; k < w; k++) begin
            i_sb_busy = 1'b1;
            i_sb_busy_fall = (k == 2);
            step();
            checks++;
            if (a_valid !== 1'b0 || a_done !== 1'b0) begin
                failures++;
                $display("FAIL %s busy_k%0d: valid=%b done=%b, required 0 0", tag, k, a_valid, a_done);
            end
        end
        i_sb_busy = 1'b0; i_sb_busy_fall = 1'b0;
        step();
        checks++;
        if (a_valid !== 1'b1 || a_code !== RESP || a_data !== neg) begin
            failures++;
            $display("FAIL %s send: valid=%b code=%h data=%h, required 1 %h %h",
                     tag, a_valid, a_code, a_data, RESP, neg);
        end
        if (abort) begin
            i_en = 1'b0;
            step();
            checks++;
            if ({a_valid, a_chk, a_done, a_err, a_code, a_data} !== 24'h0 || a_neg !== neg) begin
                failures++;
                $display("FAIL %s abort: valid=%b code=%h data=%h done=%b neg=%h, required 0 0 0 0 %h",
                         tag, a_valid, a_code, a_data, a_done, a_neg, neg);
            end
            $display("txn %s: d=%0d data=%h -> aborted in send", tag, d, data);
            return;
        end
        i_sb_busy = 1'b1;
        for (int k = 0; k < h; k++) begin
            step();
            checks++;
            if (a_valid !== 1'b1 || a_code !== RESP || a_data !== neg || a_done !== 1'b0) begin
                failures++;
                $display("FAIL %s send_hold%0d: valid=%b code=%h data=%h done=%b, required 1 %h %h 0",
                         tag, k, a_valid, a_code, a_data, a_done, RESP, neg);
            end
        end
        i_sb_busy = 1'b0; i_sb_busy_fall = 1'b1;
        step();
        i_sb_busy_fall = 1'b0;
        checks++;
        if (a_valid !== 1'b0 || a_code !== 4'h0 || a_data !== 16'h0 || a_done !== 1'b1 || a_err !== 1'b0) begin
            failures++;
            $display("FAIL %s done: valid=%b code=%h data=%h done=%b err=%b, required 0 0 0 1 0",
                     tag, a_valid, a_code, a_data, a_done, a_err);
        end
        $display("txn %s: d=%0d data=%h cap=%h mask=%h neg=%h -> done", tag, d, data, cap, mask, neg);
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        #12;
        checks++;
        if ({a_valid, a_chk, a_done, a_err, a_code, a_data, a_neg} !== 40'h0) begin
            failures++;
            $display("FAIL reset: outputs=%h required 0", {a_valid, a_chk, a_done, a_err, a_code, a_data, a_neg});
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_local_cap = 16'hFFFF; i_mandatory_mask = 16'h0; i_en = 1'b1;
        step();
        i_sb_valid = 1'b1; i_decoded_sb_msg = REQ; i_sb_data = 16'h1234;
        step();
        i_sb_valid = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        checks++;
        if (a_chk !== 1'b0 || a_neg !== 16'h0) begin
            failures++;
            $display("FAIL async_reset: chk=%b neg=%h, required 0 0000", a_chk, a_neg);
        end
        i_en = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        exp_neg = 16'h0;
        $display("txn reset: outputs cleared");
    endtask

    task automatic test_timeout();
        i_en = 1'b1;
        step();
        for (int k = 1; k <= TO_B; k++) begin
            step();
            checks++;
            if (b_err !== (k == TO_B) || a_err !== 1'b0) begin
                failures++;
                $display("FAIL timeout_k%0d: b_err=%b a_err=%b, required %b 0", k, b_err, a_err, (k == TO_B));
            end
        end
        $display("txn timeout: b_err rose after %0d wait cycles", TO_B);
        go_idle("timeout");
    endtask

    task automatic test_spurious();
        i_local_cap = 16'hFFFF; i_mandatory_mask = 16'h0;
        i_en = 1'b1;
        step();
        i_sb_valid = 1'b1; i_decoded_sb_msg = RESP; i_sb_data = 16'hBEEF;
        for (int k = 1; k <= TO_B; k++) step();
        checks++;
        if (a_chk !== 1'b0 || a_neg !== exp_neg || b_err !== 1'b1) begin
            failures++;
            $display("FAIL spurious_wait: a_chk=%b a_neg=%h b_err=%b, required 0 %h 1", a_chk, a_neg, exp_neg, b_err);
        end
        i_decoded_sb_msg = REQ; i_sb_data = 16'h5A5A;
        step();
        i_sb_valid = 1'b0;
        exp_neg = 16'h5A5A;
        i_sb_busy = 1'b1;
        step();
        i_sb_busy_fall = 1'b1;
        step();
        i_sb_busy_fall = 1'b0;
        checks++;
        if (a_valid !== 1'b0 || a_done !== 1'b0) begin
            failures++;
            $display("FAIL spurious_fall: valid=%b done=%b, required 0 0", a_valid, a_done);
        end
        i_sb_busy = 1'b0;
        step();
        i_sb_busy_fall = 1'b1;
        step();
        i_sb_busy_fall = 1'b0;
        i_sb_valid = 1'b1; i_decoded_sb_msg = REQ; i_sb_data = 16'h0F0F;
        step();
        step();
        i_sb_valid = 1'b0;
        checks++;
        if (a_done !== 1'b1 || a_chk !== 1'b0 || a_neg !== 16'h5A5A || a_valid !== 1'b0) begin
            failures++;
            $display("FAIL spurious_done: done=%b chk=%b neg=%h valid=%b, required 1 0 5a5a 0",
                     a_done, a_chk, a_neg, a_valid);
        end
        go_idle("spurious");
        i_en = 1'b1;
        step();
        i_en = 1'b0; i_sb_valid = 1'b1; i_decoded_sb_msg = REQ; i_sb_data = 16'h7777;
        step();
        i_sb_valid = 1'b0;
        checks++;
        if (a_chk !== 1'b0 || a_neg !== exp_neg) begin
            failures++;
            $display("FAIL req_with_disable: chk=%b neg=%h, required 0 %h", a_chk, a_neg, exp_neg);
        end
        $display("txn spurious: ignored traffic, neg=%h", a_neg);
        go_idle("spurious2");
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            logic [15:0] data, cap, mask;
            data = 16'($urandom);
            cap  = 16'($urandom);
            mask = ($urandom_range(0, 2) != 0) ? (16'($urandom) & data & cap) : 16'($urandom);
            run_flow($urandom_range(1, 12), data, cap, mask, $urandom_range(0, 4),
                     $urandom_range(0, 3), 1'b0, "random");
            go_idle("random");
        end
    endtask

    initial begin
        test_reset();
        run_flow(5, 16'h00F3, 16'hFFFF, 16'h0003, 0, 3, 1'b0, "nominal");
        go_idle("nominal");
        run_flow(3, 16'h00FF, 16'h00F0, 16'h0001, 0, 0, 1'b0, "mand_miss");
        go_idle("mand_miss");
        test_timeout();
        run_flow(TO_B, 16'hA5C3, 16'hFF0F, 16'h0003, 0, 1, 1'b0, "last_cycle_req");
        go_idle("last_cycle_req");
        run_flow(4, 16'h3C3C, 16'hFFFF, 16'h0C0C, 20, 2, 1'b0, "busy20");
        go_idle("busy20");
        run_flow(6, 16'h1111, 16'hFFFF, 16'h0001, 1, 0, 1'b1, "abort");
        go_idle("abort");
        run_flow(TO_B, 16'h2222, 16'hFFFF, 16'h0002, 0, 1, 1'b0, "restart");
        go_idle("restart");
        test_spurious();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
